fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader_pkg.sv | 25 ++
 rtl/fifo_stream_reader_buf.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 103 ++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
// Optional statistics counters are enabled with FIFO_STREAM_READER_STATS_EN.
package fifo_stream_reader_pkg;

  localparam int unsigned BUF_DEPTH      = 3;
  localparam int unsigned DEF_FIFO_WIDTH = 16;
  localparam int unsigned DEF_CNT_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Map buffered + in-flight occupancy onto the reader state.
  function automatic state_t level_state(input logic [2:0] level);
    if (level == 3'd0)
      return IDLE;
    else if (level >= 3'(BUF_DEPTH))
      return HOLD;
    else
      return RUN;
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// 3-entry in-order skid queue between the FIFO read port and the stream.
// Pointers wrap 2 -> 0; push into a full queue is prevented by the caller.
module fifo_stream_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [1:0]       o_count,
  output logic [WIDTH-1:0] o_head
);

  logic [WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_count;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(BUF_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Storage, pointers and occupancy; push and pop in the same cycle keep count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (i_pop)
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads words from a FIFO and presents them as a valid/ready stream.
// Macro FIFO_STREAM_READER_STATS_EN enables rd_words/uf_count; otherwise both are 0.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  empty,
  input  logic                  underflow,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  err_clr,
  output logic                  err_underflow,
  output logic [CNT_WIDTH-1:0]  rd_words,
  output logic [CNT_WIDTH-1:0]  uf_count
);

  state_t     r_state;
  logic       r_inflight;
  logic       r_err;
  logic [1:0] w_count;
  logic [2:0] w_level;
  logic [2:0] w_level_nxt;
  logic       w_push;
  logic       w_pop;
  logic       w_uf_evt;

  // Occupancy counts the in-flight read so the queue can never overflow.
  assign w_level  = {1'b0, w_count} + {2'b00, r_inflight};
  // Reset gates the request so no read is seen before the first edge after release.
  assign rd_en    = rst_n & ~empty & (r_state != HOLD) & (w_level < 3'(BUF_DEPTH));
  assign w_uf_evt = r_inflight & underflow;
  assign w_push   = r_inflight & ~underflow;
  assign m_valid  = (w_count != 2'd0);
  assign w_pop    = m_valid & m_ready;
  assign w_level_nxt = {1'b0, w_count} + {2'b00, w_push} - {2'b00, w_pop} + {2'b00, rd_en};

  fifo_stream_reader_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (data_out),
    .i_pop   (w_pop),
    .o_count (w_count),
    .o_head  (m_data)
  );

  // Track the outstanding read and derive state from next-cycle occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_state    <= IDLE;
    end else begin
      r_inflight <= rd_en;
      r_state    <= level_state(w_level_nxt);
    end
  end

  // Sticky underflow flag; a new underflow wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err <= 1'b0;
    else if (w_uf_evt)
      r_err <= 1'b1;
    else if (err_clr)
      r_err <= 1'b0;
  end

  assign err_underflow = r_err;

`ifdef FIFO_STREAM_READER_STATS_EN
  logic [CNT_WIDTH-1:0] r_rd_words;
  logic [CNT_WIDTH-1:0] r_uf_count;

  // Free-running statistics counters, wrapping modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_words <= '0;
      r_uf_count <= '0;
    end else begin
      if (w_pop)
        r_rd_words <= r_rd_words + 1'b1;
      if (w_uf_evt)
        r_uf_count <= r_uf_count + 1'b1;
    end
  end

  assign rd_words = r_rd_words;
  assign uf_count = r_uf_count;
`else
  assign rd_words = '0;
  assign uf_count = '0;
`endif

endmodule
